// File: rtl/sram_mem_arbiter.sv
// Two-port (instruction/data) SRAM-style arbiter onto a single memory port.
// One transaction in flight at a time; the response comes back as a
// one-cycle data_ok pulse on the port that issued the request.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no transaction; addr_ok offered to the priority winner
// S_INST | instruction read issued on mem_*, waiting for mem_ack
// S_DATA | data read/write issued on mem_*, waiting for mem_ack
module sram_mem_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INST = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        inst_ok_q, inst_ok_d;
  logic        data_ok_q, data_ok_d;
  logic        inst_win, data_win;

  // Size is carried for interface compatibility only; wstrb decides bytes.
  logic unused_size;
  assign unused_size = ^data_sram_size;

  // Arbitration, request capture, completion and next-state selection.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    inst_ok_d = 1'b0;
    data_ok_d = 1'b0;
    inst_win  = 1'b0;
    data_win  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_sram_req && (DATA_FIRST || !inst_sram_req)) begin
          data_win = 1'b1;
          state_d  = S_DATA;
          addr_d   = data_sram_addr[31:2];
          wr_d     = data_sram_wr;
          // reads never present byte enables to memory
          wstrb_d  = data_sram_wr ? data_sram_wstrb : 4'b0000;
          wdata_d  = data_sram_wdata;
        end else if (inst_sram_req) begin
          inst_win = 1'b1;
          state_d  = S_INST;
          addr_d   = inst_sram_addr[31:2];
          wr_d     = 1'b0;
          wstrb_d  = 4'b0000;
          wdata_d  = 32'h0;
        end
      end
      S_INST, S_DATA: begin
        if (mem_ack) begin
          rdata_d   = wr_q ? 32'h0 : mem_rdata;
          inst_ok_d = (state_q == S_INST);
          data_ok_d = (state_q == S_DATA);
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and transaction registers; reset abandons any open transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      inst_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      inst_ok_q <= inst_ok_d;
      data_ok_q <= data_ok_d;
    end
  end

  assign inst_sram_addr_ok = resetn & inst_win;
  assign data_sram_addr_ok = resetn & data_win;
  assign inst_sram_data_ok = inst_ok_q;
  assign data_sram_data_ok = data_ok_q;
  assign inst_sram_rdata   = rdata_q;
  assign data_sram_rdata   = rdata_q;

  assign mem_req   = (state_q == S_INST) || (state_q == S_DATA);
  assign mem_wr    = wr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_addr  = {addr_q, 2'b00};
  assign mem_wdata = wdata_q;

endmodule
